// File: rtl/icache_mem_sequencer_if.sv
// ----------------------------------------------------------------------------
// icache_mem_sequencer_if
// Request/response bundle between the fetch/refill/flush requesters and the
// I-cache memory sequencer, plus the memory-side control bus it drives.
//   lookup_*   : fetch read request (valid/ready)
//   refill_*   : line-fill write request with the target set's valid bits
//   flush_i    : flush request pulse; flush_done_o completion pulse
//   busy_o     : sequencer not idle
//   tag_req_o/data_req_o/tag_we_o/data_we_o/flush_en_o/valid_bit_o/
//   addr_o/tag_o/victim_way_o : memory-side strobes, address and write data
// Modports: master = requester / memory side, slave = the sequencer.
// ----------------------------------------------------------------------------
interface icache_mem_sequencer_if #(
    parameter int N_WAY = 4,
    parameter int SET_W = 6,
    parameter int TAG_W = 20
);
    logic              lookup_valid_i;
    logic [SET_W-1:0]  lookup_set_i;
    logic              lookup_ready_o;

    logic              refill_valid_i;
    logic [SET_W-1:0]  refill_set_i;
    logic [TAG_W-1:0]  refill_tag_i;
    logic [N_WAY-1:0]  refill_vbits_i;
    logic              refill_ready_o;

    logic              flush_i;
    logic              flush_done_o;
    logic              busy_o;

    logic [N_WAY-1:0]  tag_req_o;
    logic [N_WAY-1:0]  data_req_o;
    logic              tag_we_o;
    logic              data_we_o;
    logic              flush_en_o;
    logic              valid_bit_o;
    logic [SET_W-1:0]  addr_o;
    logic [TAG_W-1:0]  tag_o;
    logic [N_WAY-1:0]  victim_way_o;

    modport slave (
        input  lookup_valid_i, lookup_set_i,
        input  refill_valid_i, refill_set_i, refill_tag_i, refill_vbits_i,
        input  flush_i,
        output lookup_ready_o, refill_ready_o, flush_done_o, busy_o,
        output tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o,
        output valid_bit_o, addr_o, tag_o, victim_way_o
    );

    modport master (
        output lookup_valid_i, lookup_set_i,
        output refill_valid_i, refill_set_i, refill_tag_i, refill_vbits_i,
        output flush_i,
        input  lookup_ready_o, refill_ready_o, flush_done_o, busy_o,
        input  tag_req_o, data_req_o, tag_we_o, data_we_o, flush_en_o,
        input  valid_bit_o, addr_o, tag_o, victim_way_o
    );
endinterface

// File: rtl/icache_mem_sequencer.sv
// ----------------------------------------------------------------------------
// icache_mem_sequencer
// Arbitrates fetch lookups, line refills and flushes onto the tag/data SRAM
// control bus of an N_WAY set-associative instruction cache.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : icache_mem_sequencer_if.slave (requests in, memory strobes out)
// Priority in IDLE: flush > refill > lookup; grants are combinational.
// Victim: lowest invalid way, otherwise the round-robin pointer rr_q.
// Build option ICACHE_FLUSH_SWEEP_EN:
//   defined   : flush walks every set, clearing tag valid bits one set per
//               cycle (FLUSH state, 2^SET_W cycles), for SRAMs with no clear
//   undefined : single-cycle bulk flush through flush_en_o
// ----------------------------------------------------------------------------
module icache_mem_sequencer #(
    parameter int N_WAY = 4,
    parameter int SET_W = 6,
    parameter int TAG_W = 20
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    icache_mem_sequencer_if.slave   bus
);
    localparam int RR_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    logic [RR_W-1:0]  rr_q, rr_d;
    logic [N_WAY-1:0] free_oh;
    logic [N_WAY-1:0] rr_oh;
    logic [N_WAY-1:0] victim;
    logic             free_found;
    logic             refill_gnt;
    logic             sweep_active;

    // Lowest-index invalid way; scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_oh    = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!bus.refill_vbits_i[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    assign rr_oh  = N_WAY'(1) << rr_q;
    assign victim = free_found ? free_oh : rr_oh;

`ifdef ICACHE_FLUSH_SWEEP_EN
    typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t           state_q;
    logic [SET_W-1:0] cnt_q;

    assign sweep_active = (state_q == S_FLUSH);

    // The request cycle itself only arms the sweep; the first set write
    // happens in the following cycle. Requests during the sweep are ignored.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.flush_i) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                    end
                end
                S_FLUSH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign sweep_active = 1'b0;
`endif

    // Memory-side control. Everything is gated by rstn_i so that nothing is
    // granted or strobed while reset is held, even between clock edges.
    always_comb begin
        bus.lookup_ready_o = 1'b0;
        bus.refill_ready_o = 1'b0;
        bus.flush_done_o   = 1'b0;
        bus.busy_o         = 1'b0;
        bus.tag_req_o      = '0;
        bus.data_req_o     = '0;
        bus.tag_we_o       = 1'b0;
        bus.data_we_o      = 1'b0;
        bus.flush_en_o     = 1'b0;
        bus.valid_bit_o    = 1'b0;
        bus.addr_o         = SET_W'(0);
        bus.tag_o          = TAG_W'(0);
        bus.victim_way_o   = '0;
        refill_gnt         = 1'b0;

        if (rstn_i) begin
            if (sweep_active) begin
`ifdef ICACHE_FLUSH_SWEEP_EN
                bus.busy_o       = 1'b1;
                bus.tag_req_o    = '1;
                bus.tag_we_o     = 1'b1;
                bus.addr_o       = cnt_q;
                bus.flush_done_o = (cnt_q == '1);
`endif
            end else if (bus.flush_i) begin
`ifndef ICACHE_FLUSH_SWEEP_EN
                bus.flush_en_o   = 1'b1;
                bus.flush_done_o = 1'b1;
`endif
            end else if (bus.refill_valid_i) begin
                refill_gnt         = 1'b1;
                bus.refill_ready_o = 1'b1;
                bus.tag_req_o      = victim;
                bus.data_req_o     = victim;
                bus.victim_way_o   = victim;
                bus.tag_we_o       = 1'b1;
                bus.data_we_o      = 1'b1;
                bus.valid_bit_o    = 1'b1;
                bus.addr_o         = bus.refill_set_i;
                bus.tag_o          = bus.refill_tag_i;
            end else if (bus.lookup_valid_i) begin
                bus.lookup_ready_o = 1'b1;
                bus.tag_req_o      = '1;
                bus.data_req_o     = '1;
                bus.addr_o         = bus.lookup_set_i;
            end
        end
    end

    // Pointer only moves when it actually supplied the victim.
    always_comb begin
        rr_d = rr_q;
        if (refill_gnt && !free_found) begin
            rr_d = (rr_q == RR_W'(N_WAY - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
endmodule

// File: doc/icache_mem_sequencer.md
ICACHE_MEM_SEQUENCER -- requirements
Module: icache_mem_sequencer

Interface
REQ-001 SHALL have parameter N_WAY, default 4, number of ways driven.
REQ-002 SHALL have parameter SET_W, default 6, set-index width (64 sets).
REQ-003 SHALL have parameter TAG_W, default 20, tag width.
REQ-004 SHALL have port clk_i input 1, single clock; all state on rising edge.
REQ-005 SHALL have port rstn_i input 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports lookup_valid_i input 1, lookup_set_i input SET_W, lookup_ready_o output 1: fetch read request, valid/ready handshake.
REQ-007 SHALL have ports refill_valid_i input 1, refill_set_i input SET_W, refill_tag_i input TAG_W, refill_vbits_i input N_WAY, refill_ready_o output 1: line-fill write request plus current valid bits of the target set.
REQ-008 SHALL have ports flush_i input 1 (flush request pulse), flush_done_o output 1 (completion pulse), busy_o output 1 (state not IDLE).
REQ-009 SHALL have memory-side outputs tag_req_o N_WAY, data_req_o N_WAY, tag_we_o 1, data_we_o 1, flush_en_o 1, valid_bit_o 1, addr_o SET_W, tag_o TAG_W, victim_way_o N_WAY one-hot.

Function
REQ-010 SHALL implement states IDLE, FLUSH; FLUSH entered only when macro of REQ-025 defined.
REQ-011 SHALL arbitrate per cycle in IDLE with fixed priority flush_i > refill > lookup; exactly one request type reaches the memory per cycle.
REQ-012 Lookup granted (lookup_ready_o=1) SHALL drive tag_req_o and data_req_o all ones, we=0, addr_o=lookup_set_i, same cycle (combinational); read data returns next cycle per memory.
REQ-013 Refill granted (refill_ready_o=1) SHALL drive tag_req_o=data_req_o=victim_way_o, tag_we_o=data_we_o=1, valid_bit_o=1, tag_o=refill_tag_i, addr_o=refill_set_i.
REQ-014 Victim SHALL be lowest-index way with refill_vbits_i bit 0; if all valid, way at round-robin pointer rr_q.
REQ-015 rr_q (log2 N_WAY bits) SHALL increment, wrapping N_WAY-1 -> 0, only on a granted refill whose victim came from rr_q.
REQ-016 lookup_ready_o SHALL be 0 whenever refill_valid_i or flush_i is high or state is FLUSH; refill_ready_o SHALL be 0 when flush_i high or state FLUSH.
REQ-017 Idle cycles SHALL drive all req/we/flush_en outputs 0; addr_o, tag_o 0.
REQ-018 FLUSH (macro defined): each cycle drive tag_req_o all ones, tag_we_o=1, valid_bit_o=0, data_req_o=0, addr_o=sweep counter; counter starts 0, increments by 1.
REQ-019 FLUSH SHALL last exactly 2^SET_W cycles; cycle writing set 2^SET_W-1 returns to IDLE and asserts flush_done_o that same cycle for one cycle.
REQ-020 flush_i asserted while in FLUSH SHALL be ignored (no restart, no second done pulse).
REQ-021 Flush without macro: flush_i in IDLE SHALL assert flush_en_o for exactly that cycle with flush_done_o in the same cycle; no other request granted that cycle.
REQ-022 flush_en_o SHALL be 0 always when macro defined.

Reset
REQ-023 On rstn_i low, state=IDLE, sweep counter=0, rr_q=0 immediately, regardless of clock; a FLUSH in progress is abandoned with no flush_done_o.
REQ-024 During reset all outputs SHALL be 0 except combinational grants, which SHALL also be forced 0.

Configuration
REQ-025 Macro ICACHE_FLUSH_SWEEP_EN defined: flush by per-set tag invalidation sweep (REQ-018..020), for SRAM tag arrays lacking bulk clear; undefined: single-cycle bulk flush via flush_en_o (REQ-021), no FLUSH state or counter.

Verification
REQ-026 Lookup set 5, no other request -> same cycle lookup_ready_o=1, tag_req_o=data_req_o=4'b1111, addr_o=5, we=0.
REQ-027 Refill set 9, tag 0xABCDE, vbits 4'b1011 -> victim_way_o=4'b0100, tag_we_o=data_we_o=1, rr_q unchanged.
REQ-028 Five refills, vbits 4'b1111, from reset -> victims 0001,0010,0100,1000,0001 (wrap).
REQ-029 Lookup and refill same cycle -> refill granted, lookup_ready_o=0; lookup granted next cycle once refill drops.
REQ-030 ICACHE_FLUSH_SWEEP_EN: flush_i pulse -> 64 cycles addr_o 0..63 with valid_bit_o=0, flush_done_o on cycle 64, lookups stalled throughout; second run asserts rstn_i low at addr 30 -> IDLE, no flush_done_o.
REQ-031 Macro undefined: flush_i with concurrent lookup -> flush_en_o=1 and flush_done_o=1 one cycle, lookup_ready_o=0 that cycle.
